// File: rtl/nios_dbg_cmd_bridge_pkg.sv
// Shared types and helpers for the Nios II debug command bridge.
`timescale 1ns/1ps
package nios_dbg_pkg;

    localparam int DEF_DATA_W  = 38;
    localparam int DEF_IR_W    = 2;
    localparam int DEF_ACT_BIT = 37;
    localparam int MAX_NCH     = 32;

    // Command FIFO entry at the default widths: instruction plus shifted data.
    typedef struct packed {
        logic [DEF_IR_W-1:0]   ir;
        logic [DEF_DATA_W-1:0] data;
    } cmd_entry_t;

    // Control sequencing of the toggle synchroniser after reset.
    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } ctrl_state_t;

    // Channel index to one-hot; out-of-range indices give all zeros.
    function automatic logic [MAX_NCH-1:0] to_onehot(input int unsigned idx);
        return (idx < MAX_NCH) ? (MAX_NCH'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/nios_dbg_cmd_bridge_if.sv
// Consumer-side command handshake of the debug command bridge.
`timescale 1ns/1ps
interface nios_dbg_cmd_bridge_if #(
    parameter int DATA_W = 38,
    parameter int NCH    = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] jdo;
    logic [NCH-1:0]    take_action;
    logic [NCH-1:0]    take_no_action;

    modport master (
        output cmd_valid,
        output jdo,
        output take_action,
        output take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  jdo,
        input  take_action,
        input  take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/nios_dbg_toggle_sync.sv
// Brings the TCK-domain update toggle into clk and turns each edge of it
// into a single-cycle event, ignoring whatever level was present at reset.
`timescale 1ns/1ps
module nios_dbg_toggle_sync
    import nios_dbg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic toggle_in,
    output logic event_out
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] chain;
    logic                   ref_q;
    logic [CNT_W-1:0]       prime_cnt;
    ctrl_state_t            state;
    ctrl_state_t            next_state;

    // Synchroniser chain plus a reference flop that always trails the last stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            ref_q <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], toggle_in};
            ref_q <= chain[SYNC_STAGES-1];
        end
    end

    // Counts cycles spent priming so the reference can settle before events fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (state == ST_PRIME) begin
            prime_cnt <= prime_cnt + CNT_W'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_PRIME;
        end else begin
            state <= next_state;
        end
    end

    // Leave priming once SYNC_STAGES+1 cycles have elapsed; RUN is terminal.
    always_comb begin
        next_state = state;
        if (state == ST_PRIME && prime_cnt == CNT_W'(SYNC_STAGES)) begin
            next_state = ST_RUN;
        end
    end

    // Events are only reported while running.
    always_comb begin
        event_out = 1'b0;
        if (state == ST_RUN) begin
            event_out = chain[SYNC_STAGES-1] ^ ref_q;
        end
    end

endmodule

// File: rtl/nios_dbg_cmd_bridge.sv
// System-clock side of the JTAG debug path: buffers each Update-DR snapshot
// and hands it to the OCI consumers as a one-hot action/no-action pulse.
`timescale 1ns/1ps
module nios_dbg_cmd_bridge
    import nios_dbg_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int NCH         = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = DEF_ACT_BIT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       upd_toggle,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [DATA_W-1:0]          sr,
    input  logic                       clr_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow,
    output logic                       bad_cmd,
    nios_dbg_cmd_bridge_if.master      cmd
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              sync_event;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    entry_t            rd_entry;
    logic              rd_ir_ok;
    logic [NCH-1:0]    chan_onehot;
    logic [DATA_W-1:0] jdo_q;
    logic [NCH-1:0]    act_q;
    logic [NCH-1:0]    noact_q;
    logic              ovf_q;
    logic              bad_q;

    nios_dbg_toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .toggle_in (upd_toggle),
        .event_out (sync_event)
    );

    // FIFO status and handshake decode; status depends on registered pointers only.
    always_comb begin
        empty       = (wr_ptr == rd_ptr);
        full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop         = !empty && cmd.cmd_ready;
        push        = sync_event && (!full || pop);
        drop        = sync_event && full && !pop;
        rd_entry    = mem[rd_ptr[AW-1:0]];
        rd_ir_ok    = ({1'b0, rd_entry.ir} < (IR_W + 1)'(NCH));
        chan_onehot = NCH'(to_onehot(32'(rd_entry.ir)));
    end

    // Entry storage; the snapshot is taken in the same cycle as the event.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{ir: ir_in, data: sr};
        end
    end

    // Wrap-around pointers with an extra MSB to tell full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Delivery: register jdo and fire one pulse per pop for in-range channels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo_q   <= '0;
            act_q   <= '0;
            noact_q <= '0;
        end else begin
            act_q   <= '0;
            noact_q <= '0;
            if (pop) begin
                jdo_q <= rd_entry.data;
                if (rd_ir_ok) begin
                    if (rd_entry.data[ACT_BIT]) begin
                        act_q <= chan_onehot;
                    end else begin
                        noact_q <= chan_onehot;
                    end
                end
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (pop && !rd_ir_ok) begin
                bad_q <= 1'b1;
            end else if (clr_err) begin
                bad_q <= 1'b0;
            end
        end
    end

    assign fifo_level         = LW'(wr_ptr - rd_ptr);
    assign overflow           = ovf_q;
    assign bad_cmd            = bad_q;
    assign cmd.cmd_valid      = !empty;
    assign cmd.jdo            = jdo_q;
    assign cmd.take_action    = act_q;
    assign cmd.take_no_action = noact_q;

endmodule

// File: tb/tb_nios_dbg_cmd_bridge.sv
// Directed/randomised bench for nios_dbg_cmd_bridge with a queue-based reference.
`timescale 1ns/1ps
module tb_nios_dbg_cmd_bridge;

    localparam int S     = 2;
    localparam int DEPTH = 4;
    localparam int NCH   = 3;
    localparam int DW    = 38;
    localparam int IRW   = 2;
    localparam int ACTB  = 37;

    logic           clk;
    logic           reset_n;
    logic           upd_toggle;
    logic [IRW-1:0] ir_in;
    logic [DW-1:0]  sr;
    logic           clr_err;
    logic [2:0]     fifo_level;
    logic           overflow;
    logic           bad_cmd;

    nios_dbg_cmd_bridge_if #(.DATA_W(DW), .NCH(NCH)) cmd_if ();

    nios_dbg_cmd_bridge #(
        .DATA_W      (DW),
        .IR_W        (IRW),
        .NCH         (NCH),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (S),
        .ACT_BIT     (ACTB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .upd_toggle (upd_toggle),
        .ir_in      (ir_in),
        .sr         (sr),
        .clr_err    (clr_err),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .bad_cmd    (bad_cmd),
        .cmd        (cmd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queued commands, sampled toggle history, expected outputs.
    typedef struct {
        logic [IRW-1:0] ir;
        logic [DW-1:0]  data;
    } ent_t;

    ent_t           q[$];
    bit             hist[$];
    logic [DW-1:0]  m_jdo;
    logic [NCH-1:0] m_act;
    logic [NCH-1:0] m_noact;
    logic           m_ovf;
    logic           m_bad;

    int compared   = 0;
    int mismatched = 0;

    task automatic modelReset();
        q.delete();
        hist.delete();
        hist.push_back(1'b0);
        m_jdo   = '0;
        m_act   = '0;
        m_noact = '0;
        m_ovf   = 1'b0;
        m_bad   = 1'b0;
    endtask

    task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("cmd_valid", 64'(cmd_if.cmd_valid), 64'(q.size() != 0));
        checkOne("fifo_level", 64'(fifo_level), 64'(q.size()));
        checkOne("jdo", 64'(cmd_if.jdo), 64'(m_jdo));
        checkOne("take_action", 64'(cmd_if.take_action), 64'(m_act));
        checkOne("take_no_action", 64'(cmd_if.take_no_action), 64'(m_noact));
        checkOne("overflow", 64'(overflow), 64'(m_ovf));
        checkOne("bad_cmd", 64'(bad_cmd), 64'(m_bad));
    endtask

    // One clock edge: advance the model from the inputs seen at the edge, then compare.
    task automatic tick();
        int   n;
        bit   ev;
        bit   pop_now;
        bit   bad_now;
        bit   drop_now;
        ent_t e;
        @(posedge clk);
        if (!reset_n) begin
            modelReset();
        end else begin
            hist.push_back(upd_toggle);
            n        = hist.size() - 1;
            ev       = (n >= S + 2) && (hist[n-S] != hist[n-S-1]);
            pop_now  = (q.size() != 0) && (cmd_if.cmd_ready === 1'b1);
            bad_now  = 1'b0;
            drop_now = 1'b0;
            m_act    = '0;
            m_noact  = '0;
            if (pop_now) begin
                e     = q.pop_front();
                m_jdo = e.data;
                if (int'(e.ir) < NCH) begin
                    if (e.data[ACTB]) m_act[e.ir] = 1'b1;
                    else              m_noact[e.ir] = 1'b1;
                end else begin
                    bad_now = 1'b1;
                end
            end
            if (ev) begin
                if (q.size() < DEPTH) q.push_back('{ir_in, sr});
                else                  drop_now = 1'b1;
            end
            if (drop_now)     m_ovf = 1'b1;
            else if (clr_err) m_ovf = 1'b0;
            if (bad_now)      m_bad = 1'b1;
            else if (clr_err) m_bad = 1'b0;
        end
        #1;
        checkOutput();
    endtask

    // Present a new snapshot and flip the update toggle.
    task automatic applyStimulus(input logic [IRW-1:0] ir, input logic [DW-1:0] data);
        ir_in      = ir;
        sr         = data;
        upd_toggle = ~upd_toggle;
    endtask

    function automatic logic [DW-1:0] randData();
        return DW'({$urandom(), $urandom()});
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            pulses;
        logic [DW-1:0] d;

        reset_n          = 1'b0;
        upd_toggle       = 1'b0;
        ir_in            = '0;
        sr               = '0;
        clr_err          = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        modelReset();
        #3;
        checkOutput();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (S + 2) tick();

        $display("[TB] single command");
        cmd_if.cmd_ready = 1'b1;
        applyStimulus(2'd2, 38'h22_1234_5678);
        tick();
        tick();
        tick();
        checkOne("single_valid_after_push", 64'(cmd_if.cmd_valid), 64'd1);
        tick();
        checkOne("single_take_action", 64'(cmd_if.take_action), 64'b100);
        checkOne("single_jdo", 64'(cmd_if.jdo), 64'h22_1234_5678);
        tick();
        checkOne("single_pulse_width", 64'(cmd_if.take_action), 64'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(IRW'($urandom_range(0, NCH - 1)), randData());
            repeat (S + 3) begin
                cmd_if.cmd_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        cmd_if.cmd_ready = 1'b1;
        repeat (6) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        $display("[TB] back-pressure and overflow");
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(IRW'(i % NCH), randData());
            repeat (S + 3) tick();
        end
        checkOne("bp_level_full", 64'(fifo_level), 64'd4);
        checkOne("bp_overflow_set", 64'(overflow), 64'd1);
        cmd_if.cmd_ready = 1'b1;
        pulses = 0;
        repeat (6) begin
            tick();
            if ((|cmd_if.take_action) || (|cmd_if.take_no_action)) pulses++;
        end
        checkOne("bp_pulse_count", 64'(pulses), 64'd4);
        checkOne("bp_drained", 64'(cmd_if.cmd_valid), 64'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOne("ovf_cleared", 64'(overflow), 64'd0);

        $display("[TB] full with simultaneous push and pop");
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(IRW'($urandom_range(0, NCH - 1)), randData());
            repeat (S + 3) tick();
        end
        checkOne("fpp_level_before", 64'(fifo_level), 64'd4);
        applyStimulus(2'd1, randData());
        tick();
        tick();
        cmd_if.cmd_ready = 1'b1;
        tick();
        cmd_if.cmd_ready = 1'b0;
        checkOne("fpp_level_kept", 64'(fifo_level), 64'd4);
        checkOne("fpp_no_overflow", 64'(overflow), 64'd0);
        cmd_if.cmd_ready = 1'b1;
        repeat (6) tick();

        $display("[TB] invalid IR");
        d = randData();
        applyStimulus(2'd3, d);
        repeat (S + 2) tick();
        checkOne("bad_no_pulse", 64'(cmd_if.take_action | cmd_if.take_no_action), 64'd0);
        checkOne("bad_flag_set", 64'(bad_cmd), 64'd1);
        checkOne("bad_jdo_updated", 64'(cmd_if.jdo), 64'(d));
        repeat (2) tick();
        applyStimulus(2'd3, randData());
        repeat (S + 1) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOne("bad_set_wins_clear", 64'(bad_cmd), 64'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOne("bad_cleared", 64'(bad_cmd), 64'd0);

        $display("[TB] reset mid-operation");
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(IRW'($urandom_range(0, NCH - 1)), randData());
            repeat (S + 3) tick();
        end
        checkOne("rst_level_before", 64'(fifo_level), 64'd3);
        applyStimulus(2'd0, randData());
        tick();
        reset_n    = 1'b0;
        upd_toggle = 1'b1;
        modelReset();
        #2;
        checkOutput();
        checkOne("rst_level_zero", 64'(fifo_level), 64'd0);
        checkOne("rst_jdo_zero", 64'(cmd_if.jdo), 64'd0);
        tick();
        tick();
        reset_n          = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        pulses           = 0;
        repeat (10) begin
            tick();
            if ((|cmd_if.take_action) || (|cmd_if.take_no_action)) pulses++;
        end
        checkOne("rst_no_pulses", 64'(pulses), 64'd0);
        checkOne("rst_level_toggle_no_event", 64'(cmd_if.cmd_valid), 64'd0);

        $display("[TB] recovery after reset");
        d = randData();
        d[ACTB] = 1'b0;
        applyStimulus(2'd1, d);
        repeat (S + 2) tick();
        checkOne("recover_no_action", 64'(cmd_if.take_no_action), 64'b010);
        checkOne("recover_jdo", 64'(cmd_if.jdo), 64'(d));
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
